// File: rtl/usbf_csr_arb.sv
// CSR access arbiter: shares one CSR port between the host (AHB) path and the
// USB engine, round-robin, with single-cycle strobes and fixed access latency.
module usbf_csr_arb #(
    parameter int AW     = 32,
    parameter int RD_LAT = 1,
    parameter int WR_LAT = 0
) (
    input  logic          hclk_i,
    input  logic          hrst_i,
    input  logic          h_req_i,
    input  logic          h_wr_i,
    input  logic [AW-1:0] h_addr_i,
    input  logic [31:0]   h_wdata_i,
    output logic          h_ack_o,
    output logic [31:0]   h_rdata_o,
    input  logic          e_req_i,
    input  logic          e_wr_i,
    input  logic [AW-1:0] e_addr_i,
    input  logic [31:0]   e_wdata_i,
    output logic          e_ack_o,
    output logic [31:0]   e_rdata_o,
    output logic          csr_wt_en_o,
    output logic          csr_rd_en_o,
    output logic [AW-1:0] csr_addr_o,
    output logic [31:0]   csr_wdata_o,
    input  logic [31:0]   csr_rdata_i,
    output logic          busy_o,
    output logic          last_gnt_o,
    output logic [1:0]    state_o
);
    // Handshake: a requester raises req with wr/addr/wdata and holds all four
    // stable until its one-cycle ack; req is only sampled while IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic [3:0] RD_CNT = 4'(RD_LAT);
    localparam logic [3:0] WR_CNT = 4'(WR_LAT);

    state_t     state;
    logic       cmd_wr;
    logic [3:0] cnt;
    logic       gnt_e;
    logic [3:0] lat;
    logic       done;

    // On a tie the requester that did not own the previous grant wins.
    always_comb begin
        gnt_e = (h_req_i && e_req_i) ? ~last_gnt_o : e_req_i;
        lat   = cmd_wr ? WR_CNT : RD_CNT;
        done  = ((state == ISSUE) && (lat == 4'd0)) ||
                ((state == WAIT) && (cnt == 4'd1));
    end

    always_ff @(posedge hclk_i or posedge hrst_i) begin
        if (hrst_i) begin
            state       <= IDLE;
            cmd_wr      <= 1'b0;
            cnt         <= 4'd0;
            csr_wt_en_o <= 1'b0;
            csr_rd_en_o <= 1'b0;
            csr_addr_o  <= '0;
            csr_wdata_o <= '0;
            h_ack_o     <= 1'b0;
            e_ack_o     <= 1'b0;
            h_rdata_o   <= '0;
            e_rdata_o   <= '0;
            busy_o      <= 1'b0;
            last_gnt_o  <= 1'b1;
        end else begin
            csr_wt_en_o <= 1'b0;
            csr_rd_en_o <= 1'b0;
            h_ack_o     <= 1'b0;
            e_ack_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (h_req_i || e_req_i) begin
                        state      <= ISSUE;
                        busy_o     <= 1'b1;
                        last_gnt_o <= gnt_e;
                        if (gnt_e) begin
                            cmd_wr      <= e_wr_i;
                            csr_addr_o  <= e_addr_i;
                            csr_wdata_o <= e_wdata_i;
                            csr_wt_en_o <= e_wr_i;
                            csr_rd_en_o <= ~e_wr_i;
                        end else begin
                            cmd_wr      <= h_wr_i;
                            csr_addr_o  <= h_addr_i;
                            csr_wdata_o <= h_wdata_i;
                            csr_wt_en_o <= h_wr_i;
                            csr_rd_en_o <= ~h_wr_i;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= lat;
                    state <= (lat == 4'd0) ? ACK : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ACK;
                    end
                end
                ACK: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // The edge that enters ACK is the one that ends the cycle LAT
            // cycles after the strobe, so read data is captured here.
            if (done) begin
                h_ack_o <= ~last_gnt_o;
                e_ack_o <= last_gnt_o;
                if (!cmd_wr) begin
                    if (last_gnt_o) begin
                        e_rdata_o <= csr_rdata_i;
                    end else begin
                        h_rdata_o <= csr_rdata_i;
                    end
                end
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_usbf_csr_arb.sv
// Bench for usbf_csr_arb: directed accesses against two instances (RD_LAT=1/WR_LAT=0
// and RD_LAT=3/WR_LAT=2) with an expected-transaction queue per instance.
module tb_usbf_csr_arb;
    localparam int AW   = 32;
    localparam int M_RD = 1;
    localparam int M_WR = 0;

    typedef struct packed {
        logic        who;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] strb_cyc;
        logic [31:0] ack_cyc;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic hclk = 1'b0;
    logic hrst = 1'b1;
    int   cyc  = 0;
    always #5 hclk = ~hclk;
    initial forever begin
        @(posedge hclk);
        cyc++;
    end

    // ---------------- DUT signals ----------------
    logic          h_req = 0, h_wr = 0, e_req = 0, e_wr = 0;
    logic [AW-1:0] h_addr = '0, e_addr = '0;
    logic [31:0]   h_wdata = '0, e_wdata = '0;
    logic          h_ack, e_ack, csr_wt_en, csr_rd_en, busy, last_gnt;
    logic [31:0]   h_rdata, e_rdata, csr_wdata;
    logic [31:0]   csr_rdata = '0;
    logic [AW-1:0] csr_addr;
    logic [1:0]    state;

    logic          h_req3 = 0, h_wr3 = 0, e_req3 = 0, e_wr3 = 0;
    logic [AW-1:0] h_addr3 = '0, e_addr3 = '0;
    logic [31:0]   h_wdata3 = '0, e_wdata3 = '0;
    logic          h_ack3, e_ack3, csr_wt_en3, csr_rd_en3, busy3, last_gnt3;
    logic [31:0]   h_rdata3, e_rdata3, csr_wdata3;
    logic [31:0]   csr_rdata3 = '0;
    logic [AW-1:0] csr_addr3;
    logic [1:0]    state3;

    usbf_csr_arb #(.AW(AW), .RD_LAT(M_RD), .WR_LAT(M_WR)) u_dut (
        .hclk_i(hclk), .hrst_i(hrst),
        .h_req_i(h_req), .h_wr_i(h_wr), .h_addr_i(h_addr), .h_wdata_i(h_wdata),
        .h_ack_o(h_ack), .h_rdata_o(h_rdata),
        .e_req_i(e_req), .e_wr_i(e_wr), .e_addr_i(e_addr), .e_wdata_i(e_wdata),
        .e_ack_o(e_ack), .e_rdata_o(e_rdata),
        .csr_wt_en_o(csr_wt_en), .csr_rd_en_o(csr_rd_en), .csr_addr_o(csr_addr),
        .csr_wdata_o(csr_wdata), .csr_rdata_i(csr_rdata),
        .busy_o(busy), .last_gnt_o(last_gnt), .state_o(state)
    );

    usbf_csr_arb #(.AW(AW), .RD_LAT(3), .WR_LAT(2)) u_dut3 (
        .hclk_i(hclk), .hrst_i(hrst),
        .h_req_i(h_req3), .h_wr_i(h_wr3), .h_addr_i(h_addr3), .h_wdata_i(h_wdata3),
        .h_ack_o(h_ack3), .h_rdata_o(h_rdata3),
        .e_req_i(e_req3), .e_wr_i(e_wr3), .e_addr_i(e_addr3), .e_wdata_i(e_wdata3),
        .e_ack_o(e_ack3), .e_rdata_o(e_rdata3),
        .csr_wt_en_o(csr_wt_en3), .csr_rd_en_o(csr_rd_en3), .csr_addr_o(csr_addr3),
        .csr_wdata_o(csr_wdata3), .csr_rdata_i(csr_rdata3),
        .busy_o(busy3), .last_gnt_o(last_gnt3), .state_o(state3)
    );

    // ---------------- scoreboard state ----------------
    exp_t        exp_q[$];
    exp_t        exp3_q[$];
    exp_t        mon_e, mon3_e;
    int          n_cmp = 0, n_err = 0, n_strb = 0, n_ack = 0;
    logic [31:0] h_shadow = '0, e_shadow = '0, h3_shadow = '0, e3_shadow = '0;

    logic [31:0] s_haddr [3] = '{32'h04, 32'h10, 32'h20};
    logic [31:0] s_hrd   [3] = '{32'hDEADBEEF, 32'h5A5A0001, 32'hC5C50020};
    logic [31:0] s_eaddr [3] = '{32'h30, 32'h34, 32'h38};
    logic [31:0] s_ewd   [3] = '{32'h11110030, 32'h22220034, 32'h33330038};
    logic [31:0] k_haddr [3] = '{32'h08, 32'h30, 32'h38};
    logic [31:0] k_hrd   [3] = '{32'hC5C50008, 32'h11110030, 32'h33330038};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %b, required %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- CSR models ----------------
    logic [31:0] wr_mem [64];
    logic [63:0] wr_valid;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (wr_valid[a[7:2]]) return wr_mem[a[7:2]];
        if (a == 32'h04) return 32'hDEADBEEF;
        return {16'hC5C5, a[15:0]};
    endfunction

    // Main instance: the addressed word appears one cycle after the read strobe,
    // junk in every other cycle.
    initial begin
        logic [31:0] nxt;
        wr_valid = '0;
        forever begin
            @(negedge hclk);
            nxt = csr_rd_en ? rd_word(csr_addr) : {16'hBAD0, cyc[15:0]};
            if (csr_wt_en) begin
                wr_mem[csr_addr[7:2]]   = csr_wdata;
                wr_valid[csr_addr[7:2]] = 1'b1;
            end
            @(posedge hclk);
            #1 csr_rdata = nxt;
        end
    end

    // Latency-3 instance: read data is the cycle number, so it changes every cycle.
    initial forever begin
        @(posedge hclk);
        #1 csr_rdata3 = 32'(cyc);
    end

    // ---------------- monitors ----------------
    initial forever begin
        @(negedge hclk);
        if (!hrst) begin
            if (csr_wt_en || csr_rd_en) begin
                n_strb++;
                check1("strobe_excl", csr_wt_en & csr_rd_en, 1'b0);
                check1("strobe_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q[0];
                    check1("strobe_wr", csr_wt_en, mon_e.wr);
                    check("strobe_cyc", 32'(cyc), mon_e.strb_cyc);
                    check("strobe_addr", csr_addr, mon_e.addr);
                    if (mon_e.wr) check("strobe_wdata", csr_wdata, mon_e.wdata);
                end
            end
            if (h_ack || e_ack) begin
                n_ack++;
                check1("ack_excl", h_ack & e_ack, 1'b0);
                check1("ack_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check1("ack_who", e_ack, mon_e.who);
                    check1("ack_last_gnt", last_gnt, mon_e.who);
                    check("ack_cyc", 32'(cyc), mon_e.ack_cyc);
                    if (!mon_e.wr) begin
                        if (mon_e.who) e_shadow = mon_e.rdata;
                        else h_shadow = mon_e.rdata;
                    end
                    check("h_rdata", h_rdata, h_shadow);
                    check("e_rdata", e_rdata, e_shadow);
                end
            end
        end
    end

    initial forever begin
        @(negedge hclk);
        if (!hrst) begin
            if (csr_wt_en3 || csr_rd_en3) begin
                check1("l3_strobe_expected", exp3_q.size() != 0, 1'b1);
                if (exp3_q.size() != 0) begin
                    mon3_e = exp3_q[0];
                    check1("l3_strobe_wr", csr_wt_en3, mon3_e.wr);
                    check("l3_strobe_cyc", 32'(cyc), mon3_e.strb_cyc);
                    check("l3_strobe_addr", csr_addr3, mon3_e.addr);
                end
            end
            if (h_ack3 || e_ack3) begin
                check1("l3_ack_expected", exp3_q.size() != 0, 1'b1);
                if (exp3_q.size() != 0) begin
                    mon3_e = exp3_q.pop_front();
                    check1("l3_ack_who", e_ack3, mon3_e.who);
                    check("l3_ack_cyc", 32'(cyc), mon3_e.ack_cyc);
                    if (!mon3_e.wr) begin
                        if (mon3_e.who) e3_shadow = mon3_e.rdata;
                        else h3_shadow = mon3_e.rdata;
                    end
                    check("l3_h_rdata", h_rdata3, h3_shadow);
                    check("l3_e_rdata", e_rdata3, e3_shadow);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic d3, input logic who, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int strb, input int ackc);
        exp_t e;
        e = '{who: who, wr: wr, addr: addr, wdata: wdata, rdata: rdata,
              strb_cyc: 32'(strb), ack_cyc: 32'(ackc)};
        if (d3) exp3_q.push_back(e);
        else exp_q.push_back(e);
    endtask

    task automatic drive(input logic who, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
        if (who) begin
            e_req = 1'b1; e_wr = wr; e_addr = addr; e_wdata = wdata;
        end else begin
            h_req = 1'b1; h_wr = wr; h_addr = addr; h_wdata = wdata;
        end
    endtask

    function automatic logic ack_of(input logic d3, input logic who);
        if (d3) return who ? e_ack3 : h_ack3;
        return who ? e_ack : h_ack;
    endfunction

    task automatic wait_ack(input logic d3, input logic who);
        int n = 0;
        do begin
            @(negedge hclk);
            n++;
        end while (!ack_of(d3, who) && n < 40);
        if (!ack_of(d3, who)) check1("ack_timeout", ack_of(d3, who), 1'b1);
    endtask

    task automatic access(input logic who, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata);
        int lat;
        lat = wr ? M_WR : M_RD;
        @(negedge hclk);
        push(1'b0, who, wr, addr, wdata, rdata, cyc + 1, cyc + 2 + lat);
        drive(who, wr, addr, wdata);
        wait_ack(1'b0, who);
        if (who) e_req = 1'b0;
        else h_req = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int c;
        repeat (3) @(negedge hclk);
        hrst = 1'b0;
        @(negedge hclk);
        check1("rst_h_ack", h_ack, 1'b0);
        check1("rst_e_ack", e_ack, 1'b0);
        check1("rst_wt_en", csr_wt_en, 1'b0);
        check1("rst_rd_en", csr_rd_en, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_last_gnt", last_gnt, 1'b1);
        check("rst_state", 32'(state), 32'd0);
        check("rst_h_rdata", h_rdata, 32'd0);
        check("rst_e_rdata", e_rdata, 32'd0);
        check("rst_csr_addr", csr_addr, 32'd0);
        check("rst_csr_wdata", csr_wdata, 32'd0);

        access(1'b0, 1'b0, 32'h04, 32'h0, 32'hDEADBEEF);
        access(1'b1, 1'b1, 32'h10, 32'h5A5A0001, 32'h0);
        access(1'b0, 1'b0, 32'h10, 32'h0, 32'h5A5A0001);
        access(1'b1, 1'b0, 32'h04, 32'h0, 32'hDEADBEEF);

        // Engine drops req one cycle after raising it; the write still completes.
        @(negedge hclk);
        push(1'b0, 1'b1, 1'b1, 32'h18, 32'h0BADF00D, 32'h0, cyc + 1, cyc + 2);
        drive(1'b1, 1'b1, 32'h18, 32'h0BADF00D);
        @(negedge hclk);
        e_req = 1'b0;
        wait_ack(1'b0, 1'b1);

        // Both requesting continuously: host reads and engine writes alternate.
        @(negedge hclk);
        c = cyc;
        for (int k = 0; k < 3; k++) begin
            push(1'b0, 1'b0, 1'b0, s_haddr[k], 32'h0, s_hrd[k], c + 7*k + 1, c + 7*k + 3);
            push(1'b0, 1'b1, 1'b1, s_eaddr[k], s_ewd[k], 32'h0, c + 7*k + 5, c + 7*k + 6);
        end
        drive(1'b0, 1'b0, s_haddr[0], 32'h0);
        drive(1'b1, 1'b1, s_eaddr[0], s_ewd[0]);
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    wait_ack(1'b0, 1'b0);
                    if (k < 2) drive(1'b0, 1'b0, s_haddr[k+1], 32'h0);
                    else h_req = 1'b0;
                end
            end
            begin
                for (int j = 0; j < 3; j++) begin
                    wait_ack(1'b0, 1'b1);
                    if (j < 2) drive(1'b1, 1'b1, s_eaddr[j+1], s_ewd[j+1]);
                    else e_req = 1'b0;
                end
            end
        join

        // Host keeps req high across acks: one access every 3+RD_LAT cycles.
        @(negedge hclk);
        c = cyc;
        for (int k = 0; k < 3; k++)
            push(1'b0, 1'b0, 1'b0, k_haddr[k], 32'h0, k_hrd[k], c + 4*k + 1, c + 4*k + 3);
        drive(1'b0, 1'b0, k_haddr[0], 32'h0);
        for (int k = 0; k < 3; k++) begin
            wait_ack(1'b0, 1'b0);
            if (k < 2) drive(1'b0, 1'b0, k_haddr[k+1], 32'h0);
            else h_req = 1'b0;
        end

        // Latency-3 instance: read captures the value present 3 cycles after strobe.
        @(negedge hclk);
        c = cyc;
        push(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'(c + 4), c + 1, c + 5);
        h_req3 = 1'b1; h_wr3 = 1'b0; h_addr3 = 32'h40;
        wait_ack(1'b1, 1'b0);
        h_req3 = 1'b0;
        @(negedge hclk);
        c = cyc;
        push(1'b1, 1'b1, 1'b1, 32'h44, 32'h77778888, 32'h0, c + 1, c + 4);
        e_req3 = 1'b1; e_wr3 = 1'b1; e_addr3 = 32'h44; e_wdata3 = 32'h77778888;
        wait_ack(1'b1, 1'b1);
        e_req3 = 1'b0;

        // Reset while the host read sits in WAIT, with the engine also pending.
        @(negedge hclk);
        c = cyc;
        push(1'b0, 1'b0, 1'b0, 32'h04, 32'h0, 32'hDEADBEEF, c + 1, c + 3);
        drive(1'b0, 1'b0, 32'h04, 32'h0);
        @(negedge hclk);
        drive(1'b1, 1'b0, 32'h08, 32'h0);
        @(negedge hclk);
        check("pre_rst_state", 32'(state), 32'd2);
        hrst = 1'b1;
        #1;
        check1("arst_busy", busy, 1'b0);
        check1("arst_rd_en", csr_rd_en, 1'b0);
        check1("arst_h_ack", h_ack, 1'b0);
        check1("arst_e_ack", e_ack, 1'b0);
        check1("arst_last_gnt", last_gnt, 1'b1);
        check("arst_h_rdata", h_rdata, 32'd0);
        check("arst_state", 32'(state), 32'd0);
        exp_q.delete();
        n_strb = n_strb - 1;
        h_shadow = '0; e_shadow = '0; h3_shadow = '0; e3_shadow = '0;
        @(negedge hclk);
        check1("arst_hold_ack", h_ack | e_ack, 1'b0);
        @(negedge hclk);
        c = cyc;
        push(1'b0, 1'b0, 1'b0, 32'h04, 32'h0, 32'hDEADBEEF, c + 1, c + 3);
        push(1'b0, 1'b1, 1'b0, 32'h08, 32'h0, 32'hC5C50008, c + 5, c + 7);
        hrst = 1'b0;
        fork
            begin wait_ack(1'b0, 1'b0); h_req = 1'b0; end
            begin wait_ack(1'b0, 1'b1); e_req = 1'b0; end
        join

        repeat (3) @(negedge hclk);
        check("strobes_vs_acks", 32'(n_strb), 32'(n_ack));
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("exp3_q_drained", 32'(exp3_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
